// File: rtl/hazard_scoreboard_if.sv
// Decoder/pipeline-status bundle seen by the hazard scoreboard, plus the
// stall/flush/bubble/forwarding controls it returns.
interface hazard_scoreboard_if #(
    parameter int XLEN      = 32,
    parameter int NREG_BITS = 5
);
    logic                 dec_valid;
    logic [NREG_BITS-1:0] dec_rs1_id;
    logic [NREG_BITS-1:0] dec_rs2_id;
    logic                 dec_use_rs1;
    logic                 dec_use_rs2;
    logic [NREG_BITS-1:0] dec_rd_id;
    logic                 dec_reg_write;
    logic                 dec_mem_to_reg;
    logic                 ex_redirect;
    logic                 mem_busy;
    logic                 stall_fetch;
    logic                 stall_decode;
    logic                 flush_decode;
    logic                 bubble_ex;
    logic [1:0]           fwd_a_sel;
    logic [1:0]           fwd_b_sel;
    logic [XLEN-1:0]      stall_cycles;

    modport master (
        output dec_valid, dec_rs1_id, dec_rs2_id, dec_use_rs1, dec_use_rs2,
               dec_rd_id, dec_reg_write, dec_mem_to_reg, ex_redirect, mem_busy,
        input  stall_fetch, stall_decode, flush_decode, bubble_ex,
               fwd_a_sel, fwd_b_sel, stall_cycles
    );

    modport slave (
        input  dec_valid, dec_rs1_id, dec_rs2_id, dec_use_rs1, dec_use_rs2,
               dec_rd_id, dec_reg_write, dec_mem_to_reg, ex_redirect, mem_busy,
        output stall_fetch, stall_decode, flush_decode, bubble_ex,
               fwd_a_sel, fwd_b_sel, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard controller for the 5-stage RV32I pipe: shadows EX/MEM/WB, raises
// stall/flush/bubble, registers ALU forwarding selects and counts stall cycles.
module hazard_scoreboard #(
    parameter int XLEN      = 32,
    parameter int NREG_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_scoreboard_if.slave   bus
);

    typedef struct packed {
        logic                 v;
        logic [NREG_BITS-1:0] rd;
        logic                 wr;
        logic                 ld;
        logic [NREG_BITS-1:0] rs1;
        logic [NREG_BITS-1:0] rs2;
        logic                 u1;
        logic                 u2;
    } ex_slot_t;

    typedef struct packed {
        logic                 v;
        logic [NREG_BITS-1:0] rd;
        logic                 wr;
        logic                 ld;
    } mem_slot_t;

    // WB never needs the load flag: its result is always forwardable.
    typedef struct packed {
        logic                 v;
        logic [NREG_BITS-1:0] rd;
        logic                 wr;
    } wb_slot_t;

    typedef enum logic [2:0] {
        ACT_RESET    = 3'd0,
        ACT_FREEZE   = 3'd1,
        ACT_REDIRECT = 3'd2,
        ACT_LOAD_USE = 3'd3,
        ACT_ADVANCE  = 3'd4
    } act_e;

    localparam logic [NREG_BITS-1:0] REG_X0    = {NREG_BITS{1'b0}};
    localparam logic [XLEN-1:0]      CNT_MAX   = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]      CNT_ONE   = {{(XLEN-1){1'b0}}, 1'b1};
    localparam ex_slot_t             EX_EMPTY  = {$bits(ex_slot_t){1'b0}};
    localparam mem_slot_t            MEM_EMPTY = {$bits(mem_slot_t){1'b0}};
    localparam wb_slot_t             WB_EMPTY  = {$bits(wb_slot_t){1'b0}};

    ex_slot_t        r_ex;
    mem_slot_t       r_mem;
    wb_slot_t        r_wb;
    logic [1:0]      r_fwd_a;
    logic [1:0]      r_fwd_b;
    logic [XLEN-1:0] r_stall_cycles;

    act_e            w_act;
    logic            w_lu;
    logic            w_stall;
    logic            w_flush;
    logic            w_bubble;
    ex_slot_t        w_nx;
    mem_slot_t       w_nm;
    wb_slot_t        w_nw;
    logic [1:0]      w_fwd_a;
    logic [1:0]      w_fwd_b;

    // Newest producer wins; loads in MEM are skipped because load-use bubbles them.
    function automatic logic [1:0] fwd_pick(
        input logic                 ex_v,
        input logic                 use_rs,
        input logic [NREG_BITS-1:0] rs,
        input mem_slot_t            m,
        input wb_slot_t             w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (!(ex_v && use_rs && (rs != REG_X0))) begin
            sel = 2'b00;
        end else if (m.v && m.wr && !m.ld && (m.rd == rs)) begin
            sel = 2'b01;
        end else if (w.v && w.wr && (w.rd == rs)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Load-use detection and per-cycle action priority
    always_comb begin
        w_lu  = 1'b0;
        w_act = ACT_ADVANCE;
        if (bus.dec_valid && r_ex.v && r_ex.ld && (r_ex.rd != REG_X0)) begin
            w_lu = (bus.dec_use_rs1 && (bus.dec_rs1_id == r_ex.rd)) ||
                   (bus.dec_use_rs2 && (bus.dec_rs2_id == r_ex.rd));
        end else begin
            w_lu = 1'b0;
        end
        if (rst) begin
            w_act = ACT_RESET;
        end else if (bus.mem_busy) begin
            w_act = ACT_FREEZE;
        end else if (bus.ex_redirect) begin
            w_act = ACT_REDIRECT;
        end else if (w_lu) begin
            w_act = ACT_LOAD_USE;
        end else begin
            w_act = ACT_ADVANCE;
        end
    end

    // Pipeline control outputs for the current cycle
    always_comb begin
        w_stall  = 1'b0;
        w_flush  = 1'b0;
        w_bubble = 1'b0;
        case (w_act)
            ACT_FREEZE: begin
                w_stall = 1'b1;
            end
            ACT_REDIRECT: begin
                w_flush  = 1'b1;
                w_bubble = 1'b1;
            end
            ACT_LOAD_USE: begin
                w_stall  = 1'b1;
                w_bubble = 1'b1;
            end
            default: begin
                w_stall  = 1'b0;
                w_flush  = 1'b0;
                w_bubble = 1'b0;
            end
        endcase
    end

    // Next slot contents and the forwarding selects for the next EX occupant
    always_comb begin
        w_nx.v   = bus.dec_valid;
        w_nx.rd  = bus.dec_rd_id;
        w_nx.wr  = bus.dec_reg_write && (bus.dec_rd_id != REG_X0);
        w_nx.ld  = bus.dec_mem_to_reg;
        w_nx.rs1 = bus.dec_rs1_id;
        w_nx.rs2 = bus.dec_rs2_id;
        w_nx.u1  = bus.dec_use_rs1;
        w_nx.u2  = bus.dec_use_rs2;
        w_nm.v   = r_ex.v;
        w_nm.rd  = r_ex.rd;
        w_nm.wr  = r_ex.wr;
        w_nm.ld  = r_ex.ld;
        w_nw.v   = r_mem.v;
        w_nw.rd  = r_mem.rd;
        w_nw.wr  = r_mem.wr;
        case (w_act)
            ACT_FREEZE: begin
                w_nx = r_ex;
                w_nm = r_mem;
                w_nw = r_wb;
            end
            ACT_REDIRECT, ACT_LOAD_USE: begin
                w_nx.v = 1'b0;
            end
            ACT_ADVANCE: begin
                w_nx.v = bus.dec_valid;
            end
            default: begin
                w_nx = EX_EMPTY;
                w_nm = MEM_EMPTY;
                w_nw = WB_EMPTY;
            end
        endcase
        // Recomputing during a freeze reproduces the held selects exactly.
        w_fwd_a = fwd_pick(w_nx.v, w_nx.u1, w_nx.rs1, w_nm, w_nw);
        w_fwd_b = fwd_pick(w_nx.v, w_nx.u2, w_nx.rs2, w_nm, w_nw);
    end

    // Shadow slots and registered forwarding selects
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex    <= EX_EMPTY;
            r_mem   <= MEM_EMPTY;
            r_wb    <= WB_EMPTY;
            r_fwd_a <= 2'b00;
            r_fwd_b <= 2'b00;
        end else begin
            r_ex    <= w_nx;
            r_mem   <= w_nm;
            r_wb    <= w_nw;
            r_fwd_a <= w_fwd_a;
            r_fwd_b <= w_fwd_b;
        end
    end

    // Saturating count of fetch-stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= {XLEN{1'b0}};
        end else if (w_stall && (r_stall_cycles != CNT_MAX)) begin
            r_stall_cycles <= r_stall_cycles + CNT_ONE;
        end else begin
            r_stall_cycles <= r_stall_cycles;
        end
    end

    assign bus.stall_fetch  = w_stall;
    assign bus.stall_decode = w_stall;
    assign bus.flush_decode = w_flush;
    assign bus.bubble_ex    = w_bubble;
    assign bus.fwd_a_sel    = r_fwd_a;
    assign bus.fwd_b_sel    = r_fwd_b;
    assign bus.stall_cycles = r_stall_cycles;

endmodule
